// File: rtl/fetch_unit.sv
// Instruction fetch front end: one outstanding fetch, registered instruction to decode,
// next-PC selection at accept, and flush redirect handling including in-flight drops.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] pc_out,
    output logic [31:0] link_addr,
    input  logic        branch,
    input  logic        branch_taken,
    input  logic        j,
    input  logic        jr,
    input  logic [31:0] jr_target,
    input  logic        flush,
    input  logic [31:0] flush_pc
);
    typedef enum logic [1:0] {IDLE, REQ, HOLD, DROP} state_t;

    state_t      state_reg, state_next;
    logic [31:0] fetch_pc_reg, fetch_pc_next;
    logic [31:0] drop_pc_reg, drop_pc_next;
    logic [31:0] instr_reg, instr_next;
    logic [31:0] pc_out_reg, pc_out_next;

    logic [31:0] seq_pc;
    logic [31:0] j_target;
    logic [31:0] br_target;
    logic [31:0] redirect_pc;
    logic [31:0] flush_addr;

    assign seq_pc     = pc_out_reg + 32'd4;
    assign j_target   = {seq_pc[31:28], instr_reg[25:0], 2'b00};
    assign br_target  = seq_pc + {{14{instr_reg[15]}}, instr_reg[15:0], 2'b00};
    assign flush_addr = {flush_pc[31:2], 2'b00};

    // Redirect priority at accept: jr, then j, then taken branch, then sequential.
    always_comb begin
        if (jr)
            redirect_pc = {jr_target[31:2], 2'b00};
        else if (j)
            redirect_pc = j_target;
        else if (branch && branch_taken)
            redirect_pc = br_target;
        else
            redirect_pc = seq_pc;
    end

    always_comb begin
        state_next    = state_reg;
        fetch_pc_next = fetch_pc_reg;
        drop_pc_next  = drop_pc_reg;
        instr_next    = instr_reg;
        pc_out_next   = pc_out_reg;
        case (state_reg)
            IDLE: begin
                state_next = REQ;
                if (flush)
                    fetch_pc_next = flush_addr;
            end
            REQ: begin
                if (flush) begin
                    // Without ack the request must still complete, so park in DROP.
                    if (imem_ack) begin
                        fetch_pc_next = flush_addr;
                        state_next    = REQ;
                    end else begin
                        drop_pc_next = flush_addr;
                        state_next   = DROP;
                    end
                end else if (imem_ack) begin
                    instr_next  = imem_rdata;
                    pc_out_next = fetch_pc_reg;
                    state_next  = HOLD;
                end
            end
            HOLD: begin
                if (flush) begin
                    fetch_pc_next = flush_addr;
                    state_next    = REQ;
                end else if (instr_ready) begin
                    fetch_pc_next = redirect_pc;
                    state_next    = REQ;
                end
            end
            DROP: begin
                if (imem_ack) begin
                    fetch_pc_next = flush ? flush_addr : drop_pc_reg;
                    state_next    = REQ;
                end else if (flush) begin
                    drop_pc_next = flush_addr;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            fetch_pc_reg <= RESET_PC;
            drop_pc_reg  <= RESET_PC;
            instr_reg    <= 32'd0;
            pc_out_reg   <= RESET_PC;
        end else begin
            state_reg    <= state_next;
            fetch_pc_reg <= fetch_pc_next;
            drop_pc_reg  <= drop_pc_next;
            instr_reg    <= instr_next;
            pc_out_reg   <= pc_out_next;
        end
    end

    assign imem_req    = (state_reg == REQ) || (state_reg == DROP);
    assign imem_addr   = {fetch_pc_reg[31:2], 2'b00};
    assign instr_valid = (state_reg == HOLD);
    assign instr       = instr_reg;
    assign pc_out      = pc_out_reg;
    assign link_addr   = seq_pc;

    // Low address bits are forced to zero on every path into the fetch address.
    logic unused_low_bits;
    assign unused_low_bits = ^{jr_target[1:0], flush_pc[1:0], fetch_pc_reg[1:0]};
endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed redirect table, hand-written flush/wrap/reset sequences,
// and a randomized run against a next-PC reference model.
module tb_fetch_unit;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'd0;
    logic [31:0] instr;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [31:0] pc_out;
    logic [31:0] link_addr;
    logic        branch = 1'b0;
    logic        branch_taken = 1'b0;
    logic        j = 1'b0;
    logic        jr = 1'b0;
    logic [31:0] jr_target = 32'd0;
    logic        flush = 1'b0;
    logic [31:0] flush_pc = 32'd0;

    int errors = 0;
    int checks = 0;

    localparam logic [31:0] NOP = 32'h0000_0000;

    fetch_unit #(.RESET_PC(32'h0000_3000)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .instr(instr), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .pc_out(pc_out), .link_addr(link_addr),
        .branch(branch), .branch_taken(branch_taken), .j(j), .jr(jr),
        .jr_target(jr_target), .flush(flush), .flush_pc(flush_pc)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        end
    endtask

    // Reference next-PC from the architectural rules, in plain arithmetic.
    function automatic logic [31:0] ref_next(input logic [31:0] pc, input logic [31:0] w,
                                             input logic b, input logic t, input logic jj,
                                             input logic jjr, input logic [31:0] tgt);
        logic [31:0] seq;
        seq = pc + 32'd4;
        if (jjr) return tgt & 32'hFFFF_FFFC;
        if (jj) return (seq & 32'hF000_0000) | ((w & 32'h03FF_FFFF) << 2);
        if (b && t) return seq + 32'($signed(w[15:0]) * 4);
        return seq;
    endfunction

    task automatic wait_req(input string nm);
        int n;
        n = 0;
        while (imem_req !== 1'b1 && n < 8) begin
            tick();
            n++;
        end
        chk1({nm, "_req"}, imem_req, 1'b1);
    endtask

    task automatic deliver(input string nm, input logic [31:0] word, input int dly,
                           input logic [31:0] exp_addr);
        wait_req(nm);
        chk({nm, "_addr"}, imem_addr, exp_addr);
        for (int d = 0; d < dly; d++) begin
            tick();
            chk({nm, "_addr_stable"}, imem_addr, exp_addr);
            chk1({nm, "_novalid"}, instr_valid, 1'b0);
        end
        imem_ack = 1'b1;
        imem_rdata = word;
        tick();
        imem_ack = 1'b0;
        imem_rdata = $urandom;
        chk1({nm, "_valid"}, instr_valid, 1'b1);
        chk({nm, "_instr"}, instr, word);
        chk({nm, "_pc"}, pc_out, exp_addr);
        chk1({nm, "_req_off"}, imem_req, 1'b0);
    endtask

    task automatic accept(input string nm, input logic b, input logic t, input logic jj,
                          input logic jjr, input logic [31:0] tgt);
        branch = b; branch_taken = t; j = jj; jr = jjr; jr_target = tgt;
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        branch = 1'b0; branch_taken = 1'b0; j = 1'b0; jr = 1'b0;
        chk1({nm, "_acc_req"}, imem_req, 1'b1);
        chk1({nm, "_acc_novalid"}, instr_valid, 1'b0);
    endtask

    typedef struct {
        logic [31:0] word;
        logic        b, t, jj, jjr;
        logic [31:0] tgt;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[7];

    task automatic random_run(input logic [31:0] start_pc);
        logic [31:0] exp_pc, pend, w, tgt, exp;
        int dly, fl_at, stall;
        logic fl, flushed, b, t, jj, jjr, hfl;
        exp_pc = start_pc;
        for (int it = 0; it < 200; it++) begin
            dly = $urandom_range(0, 3);
            fl = ($urandom_range(0, 7) == 0);
            fl_at = $urandom_range(0, dly);
            flushed = 1'b0;
            pend = 32'd0;
            w = $urandom;
            chk1("rnd_req", imem_req, 1'b1);
            chk("rnd_addr", imem_addr, exp_pc);
            for (int d = 0; d <= dly; d++) begin
                if (fl && d == fl_at) begin
                    flush = 1'b1;
                    flush_pc = $urandom;
                    pend = flush_pc & 32'hFFFF_FFFC;
                    flushed = 1'b1;
                end
                imem_ack = (d == dly);
                imem_rdata = w;
                tick();
                flush = 1'b0;
                imem_ack = 1'b0;
                if (d < dly) begin
                    chk1("rnd_wait_req", imem_req, 1'b1);
                    chk("rnd_wait_addr", imem_addr, exp_pc);
                    chk1("rnd_wait_novalid", instr_valid, 1'b0);
                end
            end
            if (flushed) begin
                chk1("rnd_drop_novalid", instr_valid, 1'b0);
                chk("rnd_drop_addr", imem_addr, pend);
                exp_pc = pend;
                continue;
            end
            chk1("rnd_valid", instr_valid, 1'b1);
            chk("rnd_instr", instr, w);
            chk("rnd_pc", pc_out, exp_pc);
            chk("rnd_link", link_addr, exp_pc + 32'd4);
            stall = $urandom_range(0, 2);
            for (int s = 0; s < stall; s++) begin
                branch = 1'($urandom); branch_taken = 1'($urandom);
                j = 1'($urandom); jr = 1'($urandom); jr_target = $urandom;
                imem_ack = 1'($urandom); imem_rdata = $urandom;
                tick();
                imem_ack = 1'b0;
                chk1("rnd_stall_valid", instr_valid, 1'b1);
                chk("rnd_stall_instr", instr, w);
                chk("rnd_stall_pc", pc_out, exp_pc);
                chk1("rnd_stall_noreq", imem_req, 1'b0);
            end
            jjr = ($urandom_range(0, 3) == 0);
            jj = ($urandom_range(0, 3) == 0);
            b = 1'($urandom);
            t = 1'($urandom);
            tgt = $urandom;
            hfl = ($urandom_range(0, 7) == 0);
            if (hfl) begin
                flush = 1'b1;
                flush_pc = $urandom;
                exp = flush_pc & 32'hFFFF_FFFC;
            end else begin
                exp = ref_next(exp_pc, w, b, t, jj, jjr, tgt);
            end
            accept("rnd", b, t, jj, jjr, tgt);
            flush = 1'b0;
            chk("rnd_next", imem_addr, exp);
            exp_pc = exp;
        end
    endtask

    initial begin
        vecs[0] = '{32'h1000_FFFC, 1'b1, 1'b1, 1'b0, 1'b0, 32'd0,         32'h0000_3004};
        vecs[1] = '{32'h1000_FFFC, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0,         32'h0000_3014};
        vecs[2] = '{32'h0800_0C10, 1'b0, 1'b0, 1'b1, 1'b0, 32'd0,         32'h0000_3040};
        vecs[3] = '{32'h0000_0000, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_3103, 32'h0000_3100};
        vecs[4] = '{32'h0800_0C10, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_4000, 32'h0000_4000};
        vecs[5] = '{32'h1000_0010, 1'b1, 1'b1, 1'b0, 1'b0, 32'd0,         32'h0000_3054};
        vecs[6] = '{32'h0800_0C10, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_7777, 32'h0000_3014};

        // Reset values
        tick(); tick();
        chk1("rst_req", imem_req, 1'b0);
        chk1("rst_valid", instr_valid, 1'b0);
        chk("rst_instr", instr, 32'd0);
        chk("rst_pc", pc_out, 32'h0000_3000);
        chk("rst_link", link_addr, 32'h0000_3004);
        rst_n = 1'b1;
        chk1("idle_noreq", imem_req, 1'b0);
        tick();
        chk1("first_req", imem_req, 1'b1);
        deliver("first", NOP, 3, 32'h0000_3000);

        // Sequential stream
        accept("seq1", 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        deliver("seq1", NOP, 0, 32'h0000_3004);
        accept("seq2", 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        deliver("seq2", 32'hDEAD_BEEF, 0, 32'h0000_3008);
        for (int s = 0; s < 4; s++) begin
            tick();
            chk1("stall_valid", instr_valid, 1'b1);
            chk("stall_instr", instr, 32'hDEAD_BEEF);
            chk("stall_pc", pc_out, 32'h0000_3008);
            chk1("stall_noreq", imem_req, 1'b0);
        end

        // Redirect table at pc_out=3010
        for (int i = 0; i < 7; i++) begin
            accept("tbl_setup", 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_3010);
            deliver("tbl_fetch", vecs[i].word, 0, 32'h0000_3010);
            chk($sformatf("tbl%0d_link", i), link_addr, 32'h0000_3014);
            accept($sformatf("tbl%0d", i), vecs[i].b, vecs[i].t, vecs[i].jj, vecs[i].jjr, vecs[i].tgt);
            chk($sformatf("tbl%0d_next", i), imem_addr, vecs[i].exp);
            deliver("tbl_done", NOP, 1, vecs[i].exp);
        end

        // Flush in HOLD wins over a simultaneous accept with j
        flush = 1'b1; flush_pc = 32'h0000_4180;
        accept("hold_flush", 1'b0, 1'b0, 1'b1, 1'b0, 32'd0);
        flush = 1'b0;
        chk("hold_flush_addr", imem_addr, 32'h0000_4180);
        deliver("hold_flush", NOP, 0, 32'h0000_4180);

        // Flush while waiting in REQ: old fetch completes and is dropped
        accept("req_flush", 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        flush = 1'b1; flush_pc = 32'h0000_4180;
        tick();
        flush = 1'b0;
        for (int d = 0; d < 2; d++) begin
            chk1("drop_req", imem_req, 1'b1);
            chk("drop_old_addr", imem_addr, 32'h0000_4184);
            chk1("drop_novalid", instr_valid, 1'b0);
            tick();
        end
        imem_ack = 1'b1; imem_rdata = 32'hBAD0_BAD0;
        tick();
        imem_ack = 1'b0;
        chk1("drop_ack_novalid", instr_valid, 1'b0);
        chk("drop_redirect", imem_addr, 32'h0000_4180);
        deliver("drop_done", NOP, 0, 32'h0000_4180);

        // Second flush during DROP replaces the pending one
        accept("drop2", 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        flush = 1'b1; flush_pc = 32'h0000_4180;
        tick();
        flush_pc = 32'h0000_4282;
        tick();
        flush = 1'b0;
        chk("drop2_old_addr", imem_addr, 32'h0000_4184);
        imem_ack = 1'b1;
        tick();
        imem_ack = 1'b0;
        chk1("drop2_novalid", instr_valid, 1'b0);
        chk("drop2_newest", imem_addr, 32'h0000_4280);
        deliver("drop2_done", NOP, 0, 32'h0000_4280);

        // Flush together with ack in REQ
        accept("flush_ack", 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        flush = 1'b1; flush_pc = 32'h0000_5000; imem_ack = 1'b1;
        tick();
        flush = 1'b0; imem_ack = 1'b0;
        chk1("flush_ack_novalid", instr_valid, 1'b0);
        chk("flush_ack_addr", imem_addr, 32'h0000_5000);
        deliver("flush_ack_done", 32'h1234_5678, 0, 32'h0000_5000);

        // Ack outside a fetch is ignored
        imem_ack = 1'b1; imem_rdata = 32'hCAFE_F00D;
        tick();
        imem_ack = 1'b0;
        chk("hold_ack_ignored", instr, 32'h1234_5678);

        // Sequential wrap
        accept("wrap_setup", 1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF);
        deliver("wrap", NOP, 0, 32'hFFFF_FFFC);
        chk("wrap_link", link_addr, 32'h0000_0000);
        accept("wrap", 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        chk("wrap_next", imem_addr, 32'h0000_0000);
        deliver("wrap_done", NOP, 0, 32'h0000_0000);

        // Randomized run
        accept("rnd_start", 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        random_run(32'h0000_0004);

        // Asynchronous reset mid-REQ
        #3;
        rst_n = 1'b0;
        #1;
        chk1("async_rst_req", imem_req, 1'b0);
        chk1("async_rst_valid", instr_valid, 1'b0);
        chk("async_rst_pc", pc_out, 32'h0000_3000);
        tick();
        rst_n = 1'b1;
        chk1("rerst_idle", imem_req, 1'b0);
        tick();
        deliver("rerst", NOP, 0, 32'h0000_3000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_3000, is the first fetch address after reset.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 imem_req  output  1  fetch request to instruction memory.
REQ-005 imem_addr  output  32  word-aligned fetch address; bits [1:0] always 0.
REQ-006 imem_ack  input  1  memory response; imem_rdata valid in the same cycle.
REQ-007 imem_rdata  input  32  fetched instruction word.
REQ-008 instr  output  32  registered instruction presented to decode.
REQ-009 instr_valid  output  1  instr, pc_out and link_addr are valid.
REQ-010 instr_ready  input  1  decode accepts the current instruction.
REQ-011 pc_out  output  32  address of instr.
REQ-012 link_addr  output  32  pc_out + 4, the jal/jalr/bgezal return address.
REQ-013 branch  input  1  decoded conditional branch, sampled on accept.
REQ-014 branch_taken  input  1  branch condition result from the execute datapath.
REQ-015 j  input  1  decoded j/jal, sampled on accept.
REQ-016 jr  input  1  decoded jr/jalr, sampled on accept.
REQ-017 jr_target  input  32  rs value for jr/jalr.
REQ-018 flush  input  1  one-cycle redirect request (exception/eret); honoured in any state.
REQ-019 flush_pc  input  32  redirect address, valid while flush is high.

Function
REQ-020 FSM states are IDLE, REQ, HOLD and DROP, with one outstanding fetch at most.
REQ-021 IDLE is the single cycle after reset release; it always goes to REQ.
REQ-022 REQ:
- imem_req=1 and imem_addr=pc_next are held stable until imem_ack.
- On ack: imem_rdata goes to instr, imem_addr goes to pc_out, and the FSM goes to HOLD.
REQ-023 HOLD: instr_valid=1; instr, pc_out and link_addr stay stable until instr_ready=1.
REQ-024 Accept (HOLD && instr_ready) loads pc_next from the sampled redirects and goes to REQ, so the next imem_req is asserted in the following cycle.
REQ-025 Latency: imem_ack in cycle N gives instr_valid in cycle N+1; accept in cycle M gives imem_req in cycle M+1.
REQ-026 Next-PC priority at accept, highest first:
- jr: jr_target with bits [1:0] cleared.
- j: {pc_out+4 [31:28], instr[25:0], 2'b00}.
- branch && branch_taken: pc_out + 4 + (sign-extended instr[15:0] << 2).
- otherwise: pc_out + 4.
REQ-027 There are no delay slots.
REQ-028 All PC arithmetic is modulo 2^32; wrap from 32'hFFFF_FFFC to 32'h0000_0000 is legal and silent.
REQ-029 flush in IDLE or HOLD: pc_next = {flush_pc[31:2], 2'b00}, instr_valid drops the next cycle, and the FSM goes to REQ.
- An accept in the same cycle is discarded; flush wins over every other redirect.
REQ-030 flush in REQ without ack goes to DROP.
- DROP keeps imem_req=1 at the old address until ack, discards that data, and goes to REQ at the flush address.
REQ-031 flush in REQ together with ack: the data is discarded and the FSM goes to REQ at the flush address.
REQ-032 flush in DROP replaces the pending flush address; the newest flush wins.
REQ-033 imem_ack outside REQ/DROP is ignored.
REQ-034 branch, j, jr and branch_taken are ignored outside an accept cycle.

Reset
REQ-035 While rst_n=0, the following hold:
- imem_req=0
- instr_valid=0
- instr=0
- pc_out=RESET_PC
- link_addr=RESET_PC+4
- state=IDLE
- pc_next=RESET_PC
REQ-036 Reset assertion mid-fetch abandons the outstanding request immediately; no ack is awaited.

Verification
REQ-037 Reset release with ack delayed 0 and 3 cycles: first imem_addr=32'h0000_3000, instr_valid rises the cycle after ack, and imem_addr stays stable while waiting.
REQ-038 Sequential stream with instr_ready high: addresses 3000, 3004, 3008; with ready held low 4 cycles, instr and pc_out stay constant and no new imem_req is issued.
REQ-039 Redirects at pc_out=32'h0000_3010:
- beq taken, imm=16'hFFFC gives next fetch 32'h0000_3004.
- beq not taken gives 32'h0000_3014.
- j, instr[25:0]=26'h0000C10 gives 32'h0000_3040.
- jr with jr_target=32'h0000_3103 gives 32'h0000_3100.
- link_addr=32'h0000_3014.
REQ-040 Priority: jr and j asserted together with jr_target=32'h0000_4000 gives a fetch at 32'h0000_4000.
REQ-041 Flush with flush_pc=32'h0000_4180:
- While waiting in REQ: one more ack is consumed and discarded with no instr_valid, then the fetch goes to 32'h0000_4180.
- In HOLD with instr_ready=1: the accept is discarded and the fetch goes to 32'h0000_4180.
REQ-042 Wrap and async reset: pc_out=32'hFFFF_FFFC sequential gives a fetch at 32'h0000_0000; rst_n low mid-REQ drops imem_req asynchronously, and the next fetch is at 32'h0000_3000.
